// File: rtl/multi_debounce_ev.sv
// multi_debounce_ev
//   Multi-channel push-button / switch debouncer with press, release and
//   long-hold event pulses. Each channel has a 2-FF synchroniser, a
//   saturating up/down integrator with hysteresis and a long-hold counter.
//   A single free-running prescaler paces every integrator and hold counter.
//
// Parameters
//   NUM_CH        number of independent channels (>=1)
//   TICK_DIV      clock cycles per integration tick (1 = every cycle)
//   STABLE_TICKS  consistent ticks needed to change the debounced level
//   LONG_TICKS    ticks of asserted level before o_long fires (0 = disabled)
//   ACTIVE_LOW    1 = pin reads 0 when pressed
//
// Ports
//   i_clk      system clock
//   i_rst      asynchronous, active-high reset
//   i_db       raw asynchronous pin inputs
//   o_level    debounced level, 1 = pressed/active
//   o_press    1-cycle pulse on o_level 0->1
//   o_release  1-cycle pulse on o_level 1->0
//   o_long     1-cycle pulse when the hold time reaches LONG_TICKS
module multi_debounce_ev #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned TICK_DIV     = 1000,
  parameter int unsigned STABLE_TICKS = 50,
  parameter int unsigned LONG_TICKS   = 1000,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_db,
  output logic [NUM_CH-1:0] o_level,
  output logic [NUM_CH-1:0] o_press,
  output logic [NUM_CH-1:0] o_release,
  output logic [NUM_CH-1:0] o_long
);

  localparam int unsigned      CNT_W   = $clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_TICKS);
  // Idle pin level; also the polarity mask applied after the synchroniser.
  localparam logic [NUM_CH-1:0] IDLE   = {NUM_CH{ACTIVE_LOW}};

  // ---------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------
  logic [NUM_CH-1:0] sync1_q, sync1_d;
  logic [NUM_CH-1:0] sync2_q, sync2_d;
  logic [NUM_CH-1:0] act;

  always_comb begin
    sync1_d = i_db;
    sync2_d = sync1_q;
    act     = sync2_q ^ IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q <= IDLE;
      sync2_q <= IDLE;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // ---------------------------------------------------------------------
  // Shared prescaler
  // ---------------------------------------------------------------------
  logic tick;

  if (TICK_DIV == 1) begin : g_no_div
    always_comb tick = 1'b1;
  end else begin : g_div
    localparam int unsigned      DIV_W    = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;

    always_comb begin
      tick  = (div_q == DIV_LAST);
      div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) div_q <= '0;
      else       div_q <= div_d;
    end
  end

  // ---------------------------------------------------------------------
  // Integrators, hysteresis level and press/release events
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] level_q, level_d;
  logic [NUM_CH-1:0] press_q, press_d;
  logic [NUM_CH-1:0] release_q, release_d;

  always_comb begin
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (tick) begin
        if (act[c] && (cnt_q[c] != CNT_MAX)) begin
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end else if (!act[c] && (cnt_q[c] != '0)) begin
          cnt_d[c] = cnt_q[c] - CNT_W'(1);
        end
      end
      // Level only moves at the two saturation points, so partial bounces
      // that leave the count strictly inside the range are ignored.
      if (cnt_d[c] == CNT_MAX) begin
        level_d[c] = 1'b1;
      end else if (cnt_d[c] == '0) begin
        level_d[c] = 1'b0;
      end
      press_d[c]   =  level_d[c] & ~level_q[c];
      release_d[c] = ~level_d[c] &  level_q[c];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= '0;
      end
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    o_level   = level_q;
    o_press   = press_q;
    o_release = release_q;
  end

  // ---------------------------------------------------------------------
  // Long-hold detection
  // ---------------------------------------------------------------------
  if (LONG_TICKS == 0) begin : g_no_long
    always_comb o_long = '0;
  end else begin : g_long
    localparam int unsigned       HOLD_W   = $clog2(LONG_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_TICKS);

    logic [HOLD_W-1:0] hold_q [NUM_CH];
    logic [HOLD_W-1:0] hold_d [NUM_CH];
    logic [NUM_CH-1:0] long_q, long_d;

    always_comb begin
      hold_d = hold_q;
      long_d = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (!level_q[c]) begin
          hold_d[c] = '0;
        end else if (tick && (hold_q[c] != HOLD_MAX)) begin
          hold_d[c] = hold_q[c] + HOLD_W'(1);
        end
        // Fires only on the step into saturation: one pulse per press.
        long_d[c] = (hold_d[c] == HOLD_MAX) && (hold_q[c] != HOLD_MAX);
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          hold_q[c] <= '0;
        end
        long_q <= '0;
      end else begin
        hold_q <= hold_d;
        long_q <= long_d;
      end
    end

    always_comb o_long = long_q;
  end

endmodule

// File: tb/tb_multi_debounce_ev.sv
// Self-checking bench for multi_debounce_ev.
//   dut_a: NUM_CH=2, TICK_DIV=1, STABLE_TICKS=4, LONG_TICKS=10, ACTIVE_LOW=1
//   dut_b: same but TICK_DIV=5, ACTIVE_LOW=0
// Expected dut_a events are queued when stimulus is driven and matched
// against observed pulses by a negedge monitor.
module tb_multi_debounce_ev;

  localparam int PRESS = 0;
  localparam int REL   = 1;
  localparam int LONG  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0;
  int errs = 0;

  logic       rst_a = 1'b0, rst_b = 1'b0;
  logic [1:0] db_a  = 2'b11, db_b = 2'b00;
  logic [1:0] lvl_a, prs_a, rel_a, lng_a;
  logic [1:0] lvl_b, prs_b, rel_b, lng_b;

  multi_debounce_ev #(
    .NUM_CH(2), .TICK_DIV(1), .STABLE_TICKS(4), .LONG_TICKS(10), .ACTIVE_LOW(1'b1)
  ) dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_db(db_a),
    .o_level(lvl_a), .o_press(prs_a), .o_release(rel_a), .o_long(lng_a)
  );

  multi_debounce_ev #(
    .NUM_CH(2), .TICK_DIV(5), .STABLE_TICKS(4), .LONG_TICKS(10), .ACTIVE_LOW(1'b0)
  ) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_db(db_b),
    .o_level(lvl_b), .o_press(prs_b), .o_release(rel_b), .o_long(lng_b)
  );

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;

  ev_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vecs++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_ev(input int c, input int ch, input int kind);
    ev_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.kind = kind;
    exp_q.push_back(e);
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Event code: cycle*16 + channel*4 + kind.
  function automatic logic [31:0] ev_code(input int c, input int ch, input int kind);
    return 32'(c * 16 + ch * 4 + kind);
  endfunction

  // Scoreboard monitor for dut_a pulses.
  always @(negedge clk) begin
    logic [1:0] p;
    ev_t        e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      chk("evt_missing", 32'hFFFF_FFFF, ev_code(e.cyc, e.ch, e.kind));
    end
    for (int k = 0; k < 3; k++) begin
      p = (k == PRESS) ? prs_a : (k == REL) ? rel_a : lng_a;
      for (int ch = 0; ch < 2; ch++) begin
        if (p[ch] === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("evt_unexpected", ev_code(cyc, ch, k), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("evt_match", ev_code(cyc, ch, k), ev_code(e.cyc, e.ch, e.kind));
          end
        end
      end
    end
  end

  // Polls dut_b channel 1 for its level rise, bounded to 40 cycles.
  task automatic wait_rise_b(input int start, output int rise, output logic pulse);
    rise  = -1;
    pulse = 1'b0;
    for (int i = 0; i < 40 && rise < 0; i++) begin
      tick_to(cyc + 1);
      if (lvl_b[1] === 1'b1) begin
        rise  = cyc - start;
        pulse = prs_b[1];
      end
    end
  endtask

  initial begin
    int   c0, r, rise;
    logic pulse;

    // 1. Asynchronous reset mid-cycle, before any clock edge.
    #2;
    rst_a = 1'b1;
    rst_b = 1'b1;
    #1;
    chk("rst_level", 32'(lvl_a), 0);
    chk("rst_press", 32'(prs_a), 0);
    chk("rst_release", 32'(rel_a), 0);
    chk("rst_long", 32'(lng_a), 0);
    chk("rst_b_level", 32'(lvl_b), 0);
    tick_to(4);
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick_to(cyc + 20);
    chk("idle_level", 32'(lvl_a), 0);

    // 6. Prescaled, active-high channel. Act rises 2 cycles after the pin;
    //    the 4th tick then lands 18..22 cycles after the pin, by phase.
    c0 = cyc;
    db_b[1] = 1'b1;
    wait_rise_b(c0, rise, pulse);
    chk("b_rise_window", 32'((rise >= 18) && (rise <= 22)), 1);
    chk("b_press_at_rise", 32'(pulse), 1);
    chk("b_ch0_idle", 32'(lvl_b[0]), 0);

    rst_b   = 1'b1;
    db_b[1] = 1'b0;
    #1;
    chk("b_rst_outputs", 32'({lvl_b, prs_b, rel_b, lng_b}), 0);
    tick_to(cyc + 2);
    rst_b = 1'b0;
    tick_to(cyc + 3);
    chk("b_no_evt_after_rst", 32'({prs_b, rel_b}), 0);

    // Reset pulse 10 cycles into the count must restart it from zero.
    c0 = cyc;
    db_b[1] = 1'b1;
    tick_to(c0 + 10);
    rst_b = 1'b1;
    #1;
    chk("b_level_in_rst", 32'(lvl_b[1]), 0);
    tick_to(cyc + 1);
    rst_b = 1'b0;
    r = cyc;
    wait_rise_b(r, rise, pulse);
    chk("b_restart_window", 32'((rise >= 18) && (rise <= 22)), 1);
    chk("b_restart_press", 32'(pulse), 1);

    // 3. Bounce: low 3, high 2, low 2, then high.
    c0 = cyc;
    db_a[0] = 1'b0;
    tick_to(c0 + 3);
    db_a[0] = 1'b1;
    tick_to(c0 + 5);
    db_a[0] = 1'b0;
    tick_to(c0 + 7);
    db_a[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick_to(cyc + 1);
      chk("bounce_level", 32'(lvl_a[0]), 0);
    end

    // 2/4. Clean press, long-hold pulse, then 50 further cycles of hold.
    c0 = cyc;
    db_a[0] = 1'b0;
    push_ev(c0 + 6, 0, PRESS);
    push_ev(c0 + 16, 0, LONG);
    tick_to(c0 + 5);
    chk("press_level_pre", 32'(lvl_a[0]), 0);
    tick_to(c0 + 6);
    chk("press_level", 32'(lvl_a[0]), 1);
    chk("press_ch1_idle", 32'(lvl_a[1]), 0);
    tick_to(c0 + 66);
    chk("hold_level", 32'(lvl_a[0]), 1);

    // 5. Release, then a second press for a fresh long pulse.
    c0 = cyc;
    db_a[0] = 1'b1;
    push_ev(c0 + 6, 0, REL);
    tick_to(c0 + 5);
    chk("release_level_pre", 32'(lvl_a[0]), 1);
    tick_to(c0 + 6);
    chk("release_level", 32'(lvl_a[0]), 0);
    tick_to(c0 + 10);

    c0 = cyc;
    db_a[0] = 1'b0;
    push_ev(c0 + 6, 0, PRESS);
    push_ev(c0 + 16, 0, LONG);
    tick_to(c0 + 17);

    // Reset mid-hold: immediate clear, no pulses, normal press afterwards.
    #2;
    rst_a = 1'b1;
    #1;
    chk("midrst_level", 32'(lvl_a), 0);
    tick_to(cyc + 3);
    rst_a = 1'b0;
    r = cyc;
    push_ev(r + 6, 0, PRESS);
    push_ev(r + 16, 0, LONG);
    tick_to(r + 5);
    chk("postrst_level_pre", 32'(lvl_a[0]), 0);
    tick_to(r + 6);
    chk("postrst_level", 32'(lvl_a[0]), 1);
    tick_to(r + 20);

    c0 = cyc;
    db_a[0] = 1'b1;
    push_ev(c0 + 6, 0, REL);
    tick_to(c0 + 10);

    // Both channels together: events in the same cycles, independently.
    c0 = cyc;
    db_a = 2'b00;
    push_ev(c0 + 6, 0, PRESS);
    push_ev(c0 + 6, 1, PRESS);
    push_ev(c0 + 16, 0, LONG);
    push_ev(c0 + 16, 1, LONG);
    tick_to(c0 + 20);
    chk("dual_level", 32'(lvl_a), 32'h3);
    c0 = cyc;
    db_a = 2'b11;
    push_ev(c0 + 6, 0, REL);
    push_ev(c0 + 6, 1, REL);
    tick_to(c0 + 10);
    chk("dual_level_off", 32'(lvl_a), 0);

    tick_to(cyc + 5);
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
